// File: rtl/sram_arbiter_if.sv
// Bus bundle for the two-port SRAM arbiter: requester ports A/B, the SRAM
// side, and the two qualifiers (clk_valid, boot_mode) that gate arbitration.
interface sram_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              clk_valid;
  logic              boot_mode;

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  // Arbiter side
  modport slave (
    input  clk_valid, boot_mode,
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  sram_rdata,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata
  );

  // Requester / SRAM-model side
  modport master (
    output clk_valid, boot_mode,
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output sram_rdata,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port SRAM arbiter. Port B always eligible, port A only outside boot
// mode; ties go to the port not granted last. One access cycle per grant,
// plus one wait cycle for reads so the SRAM output can be captured.
//
//   state  | meaning
//   IDLE   | no transaction; arbitrate eligible requests
//   ACCESS | SRAM strobed with latched request, owner gnt pulse
//   RDWAIT | SRAM read data valid; capture into owner rdata
module sram_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          arst_n,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t state;
  logic   last_b;
  logic   owner_b;

  logic a_elig;
  logic b_elig;
  logic pick_b;

  // Eligibility and tie-break: B wins if A is not eligible or A won last time.
  assign a_elig = bus.a_req & ~bus.boot_mode;
  assign b_elig = bus.b_req;
  assign pick_b = b_elig & (~a_elig | ~last_b);

  // Arbiter FSM; every output is a register written here.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state          <= IDLE;
      last_b         <= 1'b1;
      owner_b        <= 1'b0;
      bus.a_gnt      <= 1'b0;
      bus.b_gnt      <= 1'b0;
      bus.a_rvalid   <= 1'b0;
      bus.b_rvalid   <= 1'b0;
      bus.a_rdata    <= '0;
      bus.b_rdata    <= '0;
      bus.sram_en    <= 1'b0;
      bus.sram_we    <= 1'b0;
      bus.sram_addr  <= '0;
      bus.sram_wdata <= '0;
    end else if (bus.clk_valid) begin
      bus.a_gnt    <= 1'b0;
      bus.b_gnt    <= 1'b0;
      bus.a_rvalid <= 1'b0;
      bus.b_rvalid <= 1'b0;
      bus.sram_en  <= 1'b0;
      case (state)
        IDLE: begin
          if (a_elig || b_elig) begin
            owner_b        <= pick_b;
            last_b         <= pick_b;
            bus.sram_en    <= 1'b1;
            bus.sram_we    <= pick_b ? bus.b_we    : bus.a_we;
            bus.sram_addr  <= pick_b ? bus.b_addr  : bus.a_addr;
            bus.sram_wdata <= pick_b ? bus.b_wdata : bus.a_wdata;
            bus.a_gnt      <= ~pick_b;
            bus.b_gnt      <= pick_b;
            state          <= ACCESS;
          end
        end
        ACCESS: begin
          // sram_we still holds the latched direction of this access
          state       <= bus.sram_we ? IDLE : RDWAIT;
          bus.sram_we <= 1'b0;
        end
        RDWAIT: begin
          if (owner_b) begin
            bus.b_rdata  <= bus.sram_rdata;
            bus.b_rvalid <= 1'b1;
          end else begin
            bus.a_rdata  <= bus.sram_rdata;
            bus.a_rvalid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboarded bench for sram_arbiter: stimulus pushes expected grant and
// read-valid events (with the enabled-cycle they must appear in); a negedge
// monitor pops and compares whenever the DUT pulses gnt or rvalid.
module tb_sram_arbiter;

  localparam int AW = 6;
  localparam int DW = 8;

  typedef struct {
    bit            is_rv;
    bit            port_b;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk;
  logic arst_n;
  int   checks;
  int   fails;
  int   cyc;
  exp_t exp_q[$];

  logic [DW-1:0] mem [64];
  logic [DW-1:0] mem_rd;

  sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enabled-cycle counter; value k means k enabled edges have occurred.
  always @(posedge clk) if (bus.clk_valid) cyc <= cyc + 1;

  // SRAM model: one-enabled-cycle read latency.
  assign bus.sram_rdata = mem_rd;
  always @(posedge clk) begin
    if (bus.clk_valid && bus.sram_en) begin
      if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_wdata;
      else             mem_rd <= mem[bus.sram_addr];
    end
  end

  function automatic void push(bit rv, bit pb, bit we, logic [AW-1:0] a,
                               logic [DW-1:0] d, int c);
    exp_t e;
    e.is_rv = rv; e.port_b = pb; e.we = we; e.addr = a; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic check_event(input bit rv);
    exp_t e;
    bit   ok;
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: rv=%0d a_gnt=%0d b_gnt=%0d a_rvalid=%0d b_rvalid=%0d cyc=%0d expected none",
               rv, bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (!rv)
      ok = !e.is_rv && (bus.b_gnt == e.port_b) && (bus.a_gnt == !e.port_b) &&
           (bus.sram_we == e.we) && (bus.sram_addr == e.addr) &&
           (!e.we || bus.sram_wdata == e.data) && (cyc == e.cyc);
    else
      ok = e.is_rv && (bus.b_rvalid == e.port_b) && (bus.a_rvalid == !e.port_b) &&
           ((e.port_b ? bus.b_rdata : bus.a_rdata) == e.data) && (cyc == e.cyc);
    if (!ok) begin
      fails++;
      $display("FAIL %s: got gnt a/b=%0d/%0d rv a/b=%0d/%0d we=%0d addr=%0h wd=%0h rd a/b=%0h/%0h cyc=%0d; expected rv=%0d port_b=%0d we=%0d addr=%0h data=%0h cyc=%0d",
               rv ? "rvalid_event" : "grant_event", bus.a_gnt, bus.b_gnt,
               bus.a_rvalid, bus.b_rvalid, bus.sram_we, bus.sram_addr,
               bus.sram_wdata, bus.a_rdata, bus.b_rdata, cyc,
               e.is_rv, e.port_b, e.we, e.addr, e.data, e.cyc);
    end
  endtask

  // Monitor: sample on enabled cycles, away from the active edge.
  always @(negedge clk) begin
    if (bus.clk_valid) begin
      chk("en_matches_gnt", {31'd0, bus.sram_en}, {31'd0, bus.a_gnt | bus.b_gnt});
      if (bus.a_gnt || bus.b_gnt)       check_event(1'b0);
      if (bus.a_rvalid || bus.b_rvalid) check_event(1'b1);
    end
  end

  task automatic wait_cyc(input int n);
    int t;
    t = cyc + n;
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit pb, input bit req, input bit we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (pb) begin
      bus.b_req = req; bus.b_we = we; bus.b_addr = a; bus.b_wdata = d;
    end else begin
      bus.a_req = req; bus.a_we = we; bus.a_addr = a; bus.a_wdata = d;
    end
  endtask

  // Single uncontended access; returns in the cycle after completion.
  task automatic single_access(input bit pb, input bit we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [DW-1:0] rd);
    int c;
    c = cyc;
    drive(pb, 1'b1, we, a, we ? d : '0);
    push(1'b0, pb, we, a, d, c + 1);
    if (!we) push(1'b1, pb, 1'b0, a, rd, c + 3);
    wait_cyc(1);
    drive(pb, 1'b0, 1'b0, '0, '0);
    wait_cyc(we ? 1 : 2);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_outs"}, {24'd0, bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid,
                        bus.sram_en, bus.sram_we, 2'b00}, 32'd0);
    chk({tag, "_addr_wdata"}, {18'd0, bus.sram_addr, bus.sram_wdata}, 32'd0);
    chk({tag, "_rdata"}, {16'd0, bus.a_rdata, bus.b_rdata}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    logic [DW-1:0] snap_rd;
    checks = 0; fails = 0; cyc = 0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem_rd = '0;
    arst_n = 1'b0;
    bus.clk_valid = 1'b1;
    bus.boot_mode = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    arst_n = 1'b1;
    wait_cyc(1);

    // A write 0x05 <= 0xA5, then IDLE in the following cycle
    single_access(1'b0, 1'b1, 6'h05, 8'hA5, 8'h00);
    chk("idle_after_write", {30'd0, bus.sram_en, bus.a_gnt}, 32'd0);

    // B read 0x05; A rdata untouched
    single_access(1'b1, 1'b0, 6'h05, 8'h00, 8'hA5);
    chk("a_rdata_untouched", {24'd0, bus.a_rdata}, 32'h00);

    // More patterns: A read, B write at top address, A read it back
    single_access(1'b0, 1'b0, 6'h05, 8'h00, 8'hA5);
    chk("b_rdata_held", {24'd0, bus.b_rdata}, 32'hA5);
    single_access(1'b1, 1'b1, 6'h3F, 8'h5A, 8'h00);
    single_access(1'b0, 1'b0, 6'h3F, 8'h00, 8'h5A);
    chk("b_rdata_held2", {24'd0, bus.b_rdata}, 32'hA5);

    // Continuous contention after reset alternates A, B, A, B
    arst_n = 1'b0;
    wait_cyc(2);
    arst_n = 1'b1;
    wait_cyc(1);
    c = cyc;
    drive(1'b0, 1'b1, 1'b1, 6'h10, 8'h11);
    drive(1'b1, 1'b1, 1'b1, 6'h20, 8'h22);
    push(1'b0, 1'b0, 1'b1, 6'h10, 8'h11, c + 1);
    push(1'b0, 1'b1, 1'b1, 6'h20, 8'h22, c + 3);
    push(1'b0, 1'b0, 1'b1, 6'h10, 8'h11, c + 5);
    push(1'b0, 1'b1, 1'b1, 6'h20, 8'h22, c + 7);
    wait_cyc(7);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    wait_cyc(2);

    // Boot mode: only B served; A granted once boot mode drops
    c = cyc;
    bus.boot_mode = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 6'h10, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 6'h20, 8'h00);
    push(1'b0, 1'b1, 1'b0, 6'h20, 8'h00, c + 1);
    push(1'b1, 1'b1, 1'b0, 6'h20, 8'h22, c + 3);
    push(1'b0, 1'b1, 1'b0, 6'h20, 8'h00, c + 4);
    push(1'b1, 1'b1, 1'b0, 6'h20, 8'h22, c + 6);
    push(1'b0, 1'b0, 1'b0, 6'h10, 8'h00, c + 7);
    push(1'b1, 1'b0, 1'b0, 6'h10, 8'h11, c + 9);
    wait_cyc(6);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    bus.boot_mode = 1'b0;
    wait_cyc(1);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    wait_cyc(3);

    // clk_valid low in ACCESS (2 clocks) and in RDWAIT (3 clocks)
    c = cyc;
    drive(1'b1, 1'b1, 1'b0, 6'h05, 8'h00);
    push(1'b0, 1'b1, 1'b0, 6'h05, 8'h00, c + 1);
    push(1'b1, 1'b1, 1'b0, 6'h05, 8'hA5, c + 3);
    wait_cyc(1);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    bus.clk_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("frozen_access", {24'd0, bus.b_gnt, bus.sram_en, bus.sram_addr}, {24'd0, 2'b11, 6'h05});
    bus.clk_valid = 1'b1;
    wait_cyc(1);
    snap_rd = bus.b_rdata;
    bus.clk_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("frozen_rdwait", {23'd0, bus.b_rvalid, bus.b_rdata}, {23'd0, 1'b0, snap_rd});
    bus.clk_valid = 1'b1;
    wait_cyc(2);

    // Reset during RDWAIT (with clk_valid low) aborts the read
    c = cyc;
    drive(1'b0, 1'b1, 1'b0, 6'h20, 8'h00);
    push(1'b0, 1'b0, 1'b0, 6'h20, 8'h00, c + 1);
    wait_cyc(1);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    wait_cyc(1);
    arst_n = 1'b0;
    bus.clk_valid = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("rst_rdwait");
    arst_n = 1'b1;
    bus.clk_valid = 1'b1;
    wait_cyc(5);
    check_all_zero("post_abort");

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, SRAM address width (64 bytes).
REQ-002 Parameter DATA_W, default 8, SRAM data width.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  system clock; all registers update on its rising edge.
REQ-005 arst_n  input  1  reset, synchronous, active-low.
REQ-006 clk_valid  input  1  cycle enable; all registers except reset behaviour update only when high.
REQ-007 boot_mode  input  1  high = only port B served; port A requests held off.
REQ-008 a_req / b_req  input  1  access request, per port.
REQ-009 a_we / b_we  input  1  1 = write, 0 = read.
REQ-010 a_addr / b_addr  input  ADDR_W  access address.
REQ-011 a_wdata / b_wdata  input  DATA_W  write data.
REQ-012 a_gnt / b_gnt  output  1  one-cycle grant pulse; request accepted.
REQ-013 a_rvalid / b_rvalid  output  1  one-cycle read-data-valid pulse.
REQ-014 a_rdata / b_rdata  output  DATA_W  read data, valid with rvalid, held until next read on that port.
REQ-015 sram_en  output  1  SRAM access strobe.
REQ-016 sram_we  output  1  SRAM write enable, qualified by sram_en.
REQ-017 sram_addr  output  ADDR_W  SRAM address.
REQ-018 sram_wdata  output  DATA_W  SRAM write data.
REQ-019 sram_rdata  input  DATA_W  SRAM read data, valid one enabled cycle after sram_en with sram_we=0.

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS, RDWAIT; all outputs registered.
REQ-021 IDLE: if any eligible request, latch winner's we/addr/wdata, set owner, go ACCESS; else stay IDLE.
REQ-022 Eligible: b_req always; a_req only when boot_mode=0, sampled in IDLE.
REQ-023 Tie (both eligible) SHALL go to port not granted last (last_b flag); single eligible requester granted immediately.
REQ-024 ACCESS: sram_en=1, sram_we/addr/wdata = latched values, owner gnt=1, exactly one cycle.
REQ-025 ACCESS with write -> IDLE; ACCESS with read -> RDWAIT.
REQ-026 RDWAIT: capture sram_rdata into owner's rdata register, assert owner rvalid next enabled cycle, go IDLE.
REQ-027 Latency (enabled cycles, req seen at cycle 0 in IDLE): gnt at 1, rvalid+rdata at 3; max throughput one write per 2 cycles, one read per 3.
REQ-028 Requester SHALL hold req, we, addr, wdata stable until gnt; changes after gnt ignored; req still high after gnt = new request.
REQ-029 last_b SHALL update on every grant (1 for B, 0 for A).
REQ-030 sram_en, gnt, rvalid SHALL be 0 in every state/cycle other than specified; never both gnt high.
REQ-031 clk_valid=0: state, outputs and latches held unchanged; consumers sample outputs only on clk_valid=1 cycles.
REQ-032 boot_mode rising while port A transaction in ACCESS/RDWAIT: that transaction SHALL complete normally.
REQ-033 Non-owner rdata SHALL never change.

Reset
REQ-034 arst_n=0 at clock edge SHALL force IDLE, last_b=1, sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0, all gnt/rvalid=0, all rdata=0, regardless of clk_valid.
REQ-035 Reset during ACCESS/RDWAIT SHALL abort the transaction; no gnt/rvalid issued afterwards for it.

Verification
REQ-036 Reset, then a_req write addr=0x05 data=0xA5 -> a_gnt and sram_en/sram_we=1, sram_addr=0x05, sram_wdata=0xA5 in cycle 1; IDLE at cycle 2.
REQ-037 b_req read addr=0x05, SRAM returns 0xA5 -> b_gnt cycle 1, b_rvalid=1, b_rdata=0xA5 cycle 3; a_rdata unchanged.
REQ-038 a_req and b_req held high continuously after reset -> grants alternate A, B, A, B.
REQ-039 boot_mode=1, a_req and b_req high -> only b_gnt; a_gnt first after boot_mode=0.
REQ-040 clk_valid low 3 cycles mid-read -> state and outputs frozen; rvalid appears after 3 enabled cycles, 0xA5 correct.
REQ-041 Reset asserted in RDWAIT -> next cycle IDLE, all outputs zero, no rvalid.
